// File: rtl/pbkdf2_hmac132_ctrl.sv
// Final scrypt PBKDF2-HMAC-SHA256 (c=1) sequencer: drives one HMAC core through
// NBLK blocks of salt || INT(i) and collects the results into the derived key.
module pbkdf2_hmac132_ctrl #(
    parameter int NBLK    = 1,
    parameter int TIMEOUT = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [255:0]         key,
    input  logic [1023:0]        salt,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [NBLK*256-1:0]  dk,
    output logic                 hmac_enable,
    output logic [255:0]         hmac_key,
    output logic [1055:0]        hmac_msg,
    input  logic [255:0]         hmac_hash,
    input  logic                 hmac_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_STORE, S_FIN, S_ABORT
    } state_t;

    localparam int             WD_W     = $clog2(TIMEOUT) + 1;
    // Abort is taken when the incremented watchdog would reach TIMEOUT-1.
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 2);
    localparam logic [3:0]      LAST_BLK = 4'(NBLK);

    state_t                   state, state_nx;
    logic [3:0]               blk_cnt;
    logic [WD_W-1:0]          wdog;
    logic [NBLK-1:0][255:0]   dk_blk;
    logic                     wd_expire;
    logic                     last_blk;

    assign wd_expire = (wdog == WD_LAST);
    assign last_blk  = (blk_cnt == LAST_BLK);
    assign dk        = dk_blk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_ISSUE;
            S_ISSUE: state_nx = S_WAIT;
            // A completion in the final watchdog cycle still counts.
            S_WAIT: begin
                if (hmac_done)      state_nx = S_STORE;
                else if (wd_expire) state_nx = S_ABORT;
            end
            S_STORE: state_nx = last_blk ? S_FIN : S_ISSUE;
            S_FIN:   state_nx = S_IDLE;
            S_ABORT: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        error       = 1'b0;
        hmac_enable = 1'b0;
        case (state)
            S_ISSUE: begin
                busy        = 1'b1;
                hmac_enable = 1'b1;
            end
            S_WAIT, S_STORE: busy  = 1'b1;
            S_FIN:           done  = 1'b1;
            S_ABORT:         error = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hmac_key <= '0;
            hmac_msg <= '0;
            blk_cnt  <= 4'd1;
            wdog     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        hmac_key <= key;
                        hmac_msg <= {salt, 32'd1};
                        blk_cnt  <= 4'd1;
                    end
                end
                S_ISSUE: wdog <= '0;
                S_WAIT:  wdog <= wdog + WD_W'(1);
                S_STORE: begin
                    if (!last_blk) begin
                        blk_cnt        <= blk_cnt + 4'd1;
                        hmac_msg[31:0] <= {28'd0, blk_cnt + 4'd1};
                    end
                end
                default: ;
            endcase
        end
    end

    // Slices are only ever overwritten, so an aborted run keeps earlier blocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dk_blk <= '0;
        end else if (state == S_WAIT && hmac_done) begin
            for (int i = 0; i < NBLK; i++)
                if (blk_cnt == 4'(i + 1)) dk_blk[i] <= hmac_hash;
        end
    end

endmodule

// File: tb/tb_pbkdf2_hmac132_ctrl.sv
// Bench for pbkdf2_hmac132_ctrl: stub HMAC core with programmable latency and a
// block-level reference model of the derived key and completion timing.
module tb_pbkdf2_hmac132_ctrl;

    localparam int NBLK    = 4;
    localparam int TIMEOUT = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [255:0]        key;
    logic [1023:0]       salt;
    logic                busy, done, error;
    logic [NBLK*256-1:0] dk;
    logic                hmac_enable;
    logic [255:0]        hmac_key;
    logic [1055:0]       hmac_msg;
    logic [255:0]        hmac_hash;
    logic                hmac_done;

    pbkdf2_hmac132_ctrl #(.NBLK(NBLK), .TIMEOUT(TIMEOUT)) u_dut (
        .clk(clk), .rst(rst), .start(start), .key(key), .salt(salt),
        .busy(busy), .done(done), .error(error), .dk(dk),
        .hmac_enable(hmac_enable), .hmac_key(hmac_key), .hmac_msg(hmac_msg),
        .hmac_hash(hmac_hash), .hmac_done(hmac_done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Stub core state: cycles until done (-1 idle) and the hash it will return.
    int           pend = -1;
    logic [255:0] pend_hash;

    typedef struct {
        int lat;       // stub latency, 0 = core never finishes
        bit noise;     // extra start pulses while busy
        int exp_done;  // done cycle offset from the start cycle, -1 none
        int exp_err;   // error cycle offset from the start cycle, -1 none
        int exp_en;    // number of hmac_enable pulses
    } vec_t;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_w(input string nm, input logic [1055:0] act, input logic [1055:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            for (int i = 0; i < 33; i++)
                if (act[i*32 +: 32] !== exp[i*32 +: 32]) begin
                    $display("FAIL %s word %0d: got %h expected %h", nm, i,
                             act[i*32 +: 32], exp[i*32 +: 32]);
                    break;
                end
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [1023:0] rand1024();
        logic [1023:0] r;
        for (int i = 0; i < 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference: block i = low 256 bits of (salt || INT(i)) xor key, as the stub computes.
    function automatic logic [NBLK*256-1:0] model_dk(input logic [255:0] k, input logic [1023:0] s);
        logic [NBLK*256-1:0] r;
        logic [1055:0]       m;
        for (int i = 1; i <= NBLK; i++) begin
            m = {s, 32'(i)};
            r[(i-1)*256 +: 256] = m[255:0] ^ k;
        end
        return r;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},   busy, 0);
        chk({tag, "_done"},   done, 0);
        chk({tag, "_error"},  error, 0);
        chk({tag, "_enable"}, hmac_enable, 0);
        chk_w({tag, "_key"},  {800'd0, hmac_key}, '0);
        chk_w({tag, "_msg"},  hmac_msg, '0);
        chk_w({tag, "_dk"},   {32'd0, dk}, '0);
    endtask

    // One derivation: cycle 0 is the cycle start is presented; returns event offsets.
    task automatic run(input logic [255:0] k, input logic [1023:0] s, input int lat,
                       input bit noise, input int rst_at_en,
                       output int t_done, output int t_err, output int n_en,
                       output bit busy_ok, output bit msg_ok);
        t_done = -1; t_err = -1; n_en = 0; busy_ok = 1; msg_ok = 1; pend = -1;
        @(posedge clk); #1;
        start = 1'b1; key = k; salt = s; hmac_done = 1'b0;
        @(negedge clk);
        for (int t = 1; t < 400; t++) begin
            @(posedge clk); #1;
            start = 1'b0; hmac_done = 1'b0;
            if (noise && (t % 3 == 0)) begin
                start = 1'b1; key = rand256(); salt = ~s;
            end
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    hmac_done = 1'b1; hmac_hash = pend_hash; pend = -1;
                end
            end
            @(negedge clk);
            if (hmac_enable) begin
                n_en++;
                if (hmac_msg[31:0] !== 32'(n_en) || hmac_msg[1055:32] !== s || hmac_key !== k)
                    msg_ok = 0;
                if (lat > 0) begin
                    pend = lat; pend_hash = hmac_msg[255:0] ^ hmac_key;
                end
                if (rst_at_en > 0 && n_en == rst_at_en) begin
                    rst = 1'b1; #1;
                    chk_reset_outputs("midrst");
                    #1 rst = 1'b0;
                    pend = -1;
                    break;
                end
            end
            if (done || error) begin
                if (done)  t_done = t;
                if (error) t_err = t;
                if (busy) busy_ok = 0;
                break;
            end else if (!busy) begin
                busy_ok = 0;
            end
        end
        start = 1'b0; hmac_done = 1'b0; pend = -1;
        key = rand256(); salt = rand1024();
    endtask

    vec_t                vecs[$];
    logic [NBLK*256-1:0] prev_dk;

    task automatic apply(input vec_t v, input string nm);
        logic [255:0]  k;
        logic [1023:0] s;
        int  td, te, ne;
        bit  bok, mok;
        k = rand256(); s = rand1024();
        run(k, s, v.lat, v.noise, 0, td, te, ne, bok, mok);
        chk({nm, "_done_at"},  td, v.exp_done);
        chk({nm, "_error_at"}, te, v.exp_err);
        chk({nm, "_enables"},  ne, v.exp_en);
        chk({nm, "_busy"},     bok, 1);
        chk({nm, "_msg"},      mok, 1);
        if (v.exp_done > 0) prev_dk = model_dk(k, s);
        chk_w({nm, "_dk"}, {32'd0, dk}, {32'd0, prev_dk});
        @(negedge clk); @(negedge clk);
        chk({nm, "_idle_after"}, busy, 0);
        chk_w({nm, "_held"}, {hmac_msg[1055:32], hmac_key}, {s, k});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b0; key = '0; salt = '0;
        hmac_hash = '0; hmac_done = 1'b0; prev_dk = '0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Done lands NBLK*(L+2)+1 cycles after the start cycle (NBLK*(L+2)+2 counting it).
        vecs.push_back('{lat: 3,  noise: 0, exp_done: 21, exp_err: -1, exp_en: 4});
        vecs.push_back('{lat: 10, noise: 0, exp_done: 49, exp_err: -1, exp_en: 4});
        vecs.push_back('{lat: 3,  noise: 1, exp_done: 21, exp_err: -1, exp_en: 4});
        vecs.push_back('{lat: 1,  noise: 1, exp_done: 13, exp_err: -1, exp_en: 4});
        vecs.push_back('{lat: 15, noise: 0, exp_done: 69, exp_err: -1, exp_en: 4});
        vecs.push_back('{lat: 16, noise: 0, exp_done: -1, exp_err: 17, exp_en: 1});
        vecs.push_back('{lat: 0,  noise: 1, exp_done: -1, exp_err: 17, exp_en: 1});
        vecs.push_back('{lat: 5,  noise: 0, exp_done: 29, exp_err: -1, exp_en: 4});
        foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

        // Stray completions while idle must not touch dk or start anything.
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            hmac_done = 1'b1; hmac_hash = rand256();
            @(negedge clk);
            if (c == 3) begin
                chk("stray_enable", hmac_enable, 0);
                chk("stray_busy", busy, 0);
            end
        end
        @(posedge clk); #1 hmac_done = 1'b0;
        @(negedge clk);
        chk_w("stray_dk", {32'd0, dk}, {32'd0, prev_dk});
        apply('{lat: 2, noise: 0, exp_done: 17, exp_err: -1, exp_en: 4}, "after_stray");

        // Reset during block 2, then a clean run from INT=1.
        begin
            int td, te, ne;
            bit bok, mok;
            run(rand256(), rand1024(), 3, 1'b0, 2, td, te, ne, bok, mok);
            chk("midrst_enables", ne, 2);
            prev_dk = '0;
            @(negedge clk);
            chk_reset_outputs("postrst");
        end
        apply('{lat: 4, noise: 0, exp_done: 25, exp_err: -1, exp_en: 4}, "fresh");

        for (int r = 0; r < 6; r++) begin
            vec_t v;
            v.lat      = int'($urandom_range(1, 14));
            v.noise    = 1'($urandom_range(0, 1));
            v.exp_done = NBLK * (v.lat + 2) + 1;
            v.exp_err  = -1;
            v.exp_en   = NBLK;
            apply(v, $sformatf("rand%0d", r));
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
